// File: rtl/pll_seq_pkg.sv
// Shared types and reset values for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic       RV_PLL_RESET = 1'b1;
  localparam logic       RV_RST_OUT_N = 1'b0;
  localparam logic       RV_READY     = 1'b0;
  localparam logic       RV_FAIL      = 1'b0;
  localparam logic [3:0] RV_RETRY_CNT = 4'd0;
  localparam logic [7:0] RV_LOSS_CNT  = 8'd0;
  localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the reference clock domain.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for qualified lock with timeout,
// then releases the downstream reset; resequences on lock loss, parks in FAIL after retries.
//
// state        | meaning
// ST_RST_PLL   | PLL held in reset for RST_PULSE_CYC cycles
// ST_WAIT_LOCK | PLL released, waiting for synced lock
// ST_STABLE    | lock seen, qualifying for LOCK_STABLE_CYC consecutive cycles
// ST_RUN       | lock qualified, downstream reset released
// ST_FAIL      | retries exhausted, PLL held in reset until restart
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 32,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 4
) (
  input  logic       i_clkin,
  input  logic       i_rst_n,
  input  logic       i_pll_lock,
  input  logic       i_restart,
  output logic       o_pll_reset,
  output logic       o_rst_out_n,
  output logic       o_ready,
  output logic       o_fail,
  output logic [3:0] o_retry_cnt,
  output logic [7:0] o_loss_cnt
);

  localparam int PW = $clog2(RST_PULSE_CYC);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC);
  localparam int SW = $clog2(LOCK_STABLE_CYC);

  localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0] TMO_LOAD   = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] STAB_LOAD  = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]    RETRY_LIM  = 4'(MAX_RETRY);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_pulse, w_pulse_nxt;
  logic [TW-1:0] r_tmo,   w_tmo_nxt;
  logic [SW-1:0] r_stab,  w_stab_nxt;
  logic [3:0]    r_retry, w_retry_nxt;
  logic [7:0]    r_loss,  w_loss_nxt;
  logic          r_pll_reset, r_rst_out_n, r_ready, r_fail;
  logic          w_lock_s;

  sync_2ff u_sync_lock (
    .i_clk   (i_clkin),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_lock),
    .o_q     (w_lock_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pulse_nxt = r_pulse;
    w_tmo_nxt   = r_tmo;
    w_stab_nxt  = r_stab;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;

    if (i_restart) begin
      w_state_nxt = ST_RST_PLL;
      w_pulse_nxt = PULSE_LOAD;
      w_retry_nxt = '0;
    end else begin
      unique case (r_state)
        ST_RST_PLL: begin
          if (r_pulse == '0) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_tmo_nxt   = TMO_LOAD;
          end else begin
            w_pulse_nxt = r_pulse - 1'b1;
          end
        end

        ST_WAIT_LOCK, ST_STABLE: begin
          // Timeout spans both states and parks at zero so a missed hit still fires next cycle
          if (r_tmo != '0) w_tmo_nxt = r_tmo - 1'b1;
          if (r_state == ST_STABLE && r_stab != '0) w_stab_nxt = r_stab - 1'b1;

          if (r_state == ST_STABLE && !w_lock_s) begin
            w_state_nxt = ST_WAIT_LOCK;
          end else if (r_state == ST_STABLE && r_stab == '0) begin
            w_state_nxt = ST_RUN;
          end else if (r_tmo == '0) begin
            if (r_retry < RETRY_LIM) begin
              w_retry_nxt = r_retry + 4'd1;
              w_state_nxt = ST_RST_PLL;
              w_pulse_nxt = PULSE_LOAD;
            end else begin
              w_state_nxt = ST_FAIL;
            end
          end else if (r_state == ST_WAIT_LOCK && w_lock_s) begin
            w_state_nxt = ST_STABLE;
            w_stab_nxt  = STAB_LOAD;
          end
        end

        ST_RUN: begin
          if (!w_lock_s) begin
            w_state_nxt = ST_RST_PLL;
            w_pulse_nxt = PULSE_LOAD;
            w_retry_nxt = '0;
            if (r_loss != LOSS_CNT_MAX) w_loss_nxt = r_loss + 8'd1;
          end
        end

        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end

        default: begin
          w_state_nxt = ST_RST_PLL;
          w_pulse_nxt = PULSE_LOAD;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register
  always_ff @(posedge i_clkin) begin
    if (!i_rst_n) begin
      r_state     <= ST_RST_PLL;
      r_pulse     <= PULSE_LOAD;
      r_tmo       <= TMO_LOAD;
      r_stab      <= STAB_LOAD;
      r_retry     <= RV_RETRY_CNT;
      r_loss      <= RV_LOSS_CNT;
      r_pll_reset <= RV_PLL_RESET;
      r_rst_out_n <= RV_RST_OUT_N;
      r_ready     <= RV_READY;
      r_fail      <= RV_FAIL;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse     <= w_pulse_nxt;
      r_tmo       <= w_tmo_nxt;
      r_stab      <= w_stab_nxt;
      r_retry     <= w_retry_nxt;
      r_loss      <= w_loss_nxt;
      r_pll_reset <= (w_state_nxt == ST_RST_PLL) || (w_state_nxt == ST_FAIL);
      r_rst_out_n <= (w_state_nxt == ST_RUN);
      r_ready     <= (w_state_nxt == ST_RUN);
      r_fail      <= (w_state_nxt == ST_FAIL);
    end
  end

  assign o_pll_reset = r_pll_reset;
  assign o_rst_out_n = r_rst_out_n;
  assign o_ready     = r_ready;
  assign o_fail      = r_fail;
  assign o_retry_cnt = r_retry;
  assign o_loss_cnt  = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a cycle-time reference model predicts outputs per edge.
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int TO = 100;
  localparam int ST = 16;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset, rst_out_n, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_PULSE_CYC    (RP),
    .LOCK_TIMEOUT_CYC (TO),
    .LOCK_STABLE_CYC  (ST),
    .MAX_RETRY        (MR)
  ) dut (
    .i_clkin     (clk),
    .i_rst_n     (rst_n),
    .i_pll_lock  (pll_lock),
    .i_restart   (restart),
    .o_pll_reset (pll_reset),
    .o_rst_out_n (rst_out_n),
    .o_ready     (ready),
    .o_fail      (fail),
    .o_retry_cnt (retry_cnt),
    .o_loss_cnt  (loss_cnt)
  );

  typedef struct packed {
    logic       pr;
    logic       ron;
    logic       rdy;
    logic       fl;
    logic [3:0] rc;
    logic [7:0] lc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: phase plus elapsed-time counts; lock seen through a 2-deep delay line
  typedef enum {PH_PULSE, PH_WAIT, PH_QUAL, PH_RUN, PH_PARK} ph_t;
  ph_t m_ph = PH_PULSE;
  int  m_t_pulse = 0, m_t_lock = 0, m_t_qual = 0, m_retry = 0, m_loss = 0;
  bit  m_lock_q[$] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit rn, input bit rs, input bit lk);
    bit ls;
    bit tmo;
    ls = m_lock_q[0];
    if (!rn) begin
      m_ph = PH_PULSE; m_t_pulse = 0; m_retry = 0; m_loss = 0;
      m_lock_q = '{1'b0, 1'b0};
      return;
    end
    void'(m_lock_q.pop_front());
    m_lock_q.push_back(lk);
    if (rs) begin
      m_ph = PH_PULSE; m_t_pulse = 0; m_retry = 0;
      return;
    end
    case (m_ph)
      PH_PULSE: begin
        m_t_pulse++;
        if (m_t_pulse == RP) begin m_ph = PH_WAIT; m_t_lock = 0; end
      end
      PH_WAIT, PH_QUAL: begin
        m_t_lock++;
        if (m_ph == PH_QUAL) m_t_qual++;
        tmo = (m_t_lock >= TO);
        if (m_ph == PH_QUAL && !ls) m_ph = PH_WAIT;
        else if (m_ph == PH_QUAL && m_t_qual >= ST) m_ph = PH_RUN;
        else if (tmo) begin
          if (m_retry < MR) begin m_retry++; m_ph = PH_PULSE; m_t_pulse = 0; end
          else m_ph = PH_PARK;
        end else if (m_ph == PH_WAIT && ls) begin
          m_ph = PH_QUAL; m_t_qual = 0;
        end
      end
      PH_RUN: begin
        if (!ls) begin
          m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
          m_retry = 0;
          m_ph    = PH_PULSE;
          m_t_pulse = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input bit rn, input bit rs, input bit lk);
    exp_t e;
    @(negedge clk);
    rst_n = rn; restart = rs; pll_lock = lk;
    model_edge(rn, rs, lk);
    e.pr  = (m_ph == PH_PULSE) || (m_ph == PH_PARK);
    e.ron = (m_ph == PH_RUN);
    e.rdy = (m_ph == PH_RUN);
    e.fl  = (m_ph == PH_PARK);
    e.rc  = 4'(m_retry);
    e.lc  = 8'(m_loss);
    sb_q.push_back(e);
  endtask

  task automatic hold(input int n, input bit lk);
    repeat (n) step(1'b1, 1'b0, lk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pll_reset", 32'(pll_reset), 32'(e.pr));
        chk("rst_out_n", 32'(rst_out_n), 32'(e.ron));
        chk("ready",     32'(ready),     32'(e.rdy));
        chk("fail",      32'(fail),      32'(e.fl));
        chk("retry_cnt", 32'(retry_cnt), 32'(e.rc));
        chk("loss_cnt",  32'(loss_cnt),  32'(e.lc));
      end
    end
  end

  initial begin : stim
    bit lvl;
    int r;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Lock arrives at cycle 10 after release
    hold(10, 1'b0);
    hold(40, 1'b1);
    @(posedge clk); #2;
    chk("run_after_lock", 32'(ready), 32'd1);

    // Lock loss in RUN, then relock
    hold(5, 1'b0);
    hold(40, 1'b1);

    // Restart while in RUN
    step(1'b1, 1'b1, 1'b1);
    hold(40, 1'b1);

    // Reset asserted while qualifying lock
    step(1'b1, 1'b1, 1'b1);
    hold(8, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    hold(40, 1'b1);

    // No lock: retries exhaust into FAIL, then restart
    hold(3 * (RP + TO) + 20, 1'b0);
    @(posedge clk); #2;
    chk("fail_parked", 32'(fail), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    hold(5, 1'b0);

    // Bouncing lock never qualifies
    step(1'b0, 1'b0, 1'b0);
    repeat (15) begin
      hold(10, 1'b1);
      hold(2, 1'b0);
    end

    // Drive loss counter into saturation
    step(1'b1, 1'b1, 1'b1);
    hold(30, 1'b1);
    repeat (262) begin
      hold(3, 1'b0);
      hold(30, 1'b1);
    end
    @(posedge clk); #2;
    chk("loss_saturated", 32'(loss_cnt), 32'd255);

    // Randomized segments
    repeat (300) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, pll_lock);
      end else if (r < 12) begin
        step(1'b1, 1'b1, pll_lock);
      end else begin
        lvl = 1'($urandom_range(0, 1));
        hold(lvl ? $urandom_range(1, 40) : $urandom_range(1, 8), lvl);
      end
    end

    hold(3, 1'b0);
    @(posedge clk); #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
